// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the icache/dcache memory-port arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IC   = 2'd1;
    localparam logic [1:0] OWN_DC   = 2'd2;

    localparam int MEM_ARB_ADDR_W = 28;
    localparam int MEM_ARB_DATA_W = 128;

    localparam logic [3:0] STARVE_MAX = 4'hF;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == STARVE_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Fixed dcache-first winner select with an icache anti-starvation override.
// Combinational grants; the lost-arbitration counter saturates at 15.
module mem_arb_picker
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic ic_valid,
    input  logic dc_valid,
    output logic grant_ic,
    output logic grant_dc
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       ic_forced;

    always_comb begin
        ic_forced = ic_valid && (starve_cnt >= LIMIT);
        grant_dc  = arb_en && dc_valid && !ic_forced;
        grant_ic  = arb_en && ic_valid && !grant_dc;
    end

    // Only a dc win that actually made icache wait counts as a lost round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (grant_ic) begin
            starve_cnt <= 4'd0;
        end else if (grant_dc && ic_valid) begin
            starve_cnt <= sat_inc4(starve_cnt);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache misses onto one memory port: grant in IDLE, registered request next cycle,
// read data pulsed to owner one cycle after mem_resp_valid. MEM_ARB_PERF_EN adds perf_wait_cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = MEM_ARB_ADDR_W,
    parameter int DATA_W       = MEM_ARB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic                ic_req_rw,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    input  logic [DATA_W-1:0]   ic_req_data,
    input  logic [DATA_W/8-1:0] ic_req_mask,
    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic [DATA_W-1:0]   dc_req_data,
    input  logic [DATA_W/8-1:0] dc_req_mask,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_data,
    output logic [DATA_W/8-1:0] mem_req_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_wait_cycles
`endif
);

    logic [1:0] state;
    logic [1:0] owner;
    logic       arb_en;

    // Gating with reset keeps the combinational readies low while reset is held.
    assign arb_en        = (state == ARB_IDLE) && !reset;
    assign mem_req_valid = (state == ARB_REQ);

    mem_arb_picker #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_picker (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (arb_en),
        .ic_valid (ic_req_valid),
        .dc_valid (dc_req_valid),
        .grant_ic (ic_req_ready),
        .grant_dc (dc_req_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ARB_IDLE;
            owner         <= OWN_NONE;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_mask  <= '0;
            ic_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_resp_valid <= 1'b0;
            dc_resp_data  <= '0;
        end else begin
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (dc_req_ready) begin
                        owner        <= OWN_DC;
                        mem_req_rw   <= dc_req_rw;
                        mem_req_addr <= dc_req_addr;
                        mem_req_data <= dc_req_data;
                        mem_req_mask <= dc_req_mask;
                        state        <= ARB_REQ;
                    end else if (ic_req_ready) begin
                        owner        <= OWN_IC;
                        mem_req_rw   <= ic_req_rw;
                        mem_req_addr <= ic_req_addr;
                        mem_req_data <= ic_req_data;
                        mem_req_mask <= ic_req_mask;
                        state        <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready) begin
                        if (mem_req_rw) begin
                            owner <= OWN_NONE;
                            state <= ARB_IDLE;
                        end else begin
                            state <= ARB_RESP;
                        end
                    end
                end
                ARB_RESP: begin
                    if (mem_resp_valid) begin
                        if (owner == OWN_IC) begin
                            ic_resp_valid <= 1'b1;
                            ic_resp_data  <= mem_resp_data;
                        end else if (owner == OWN_DC) begin
                            dc_resp_valid <= 1'b1;
                            dc_resp_data  <= mem_resp_data;
                        end
                        owner <= OWN_NONE;
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Both requesters stalled in the same cycle still counts once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_wait_cycles <= 32'd0;
        end else if ((ic_req_valid && !ic_req_ready) || (dc_req_valid && !dc_req_ready)) begin
            perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboarded read responses, corner-case sequences.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_req_rw;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_req_data;
    logic [MW-1:0] ic_req_mask;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data;
    logic [MW-1:0] dc_req_mask;
    logic          ic_resp_valid, dc_resp_valid;
    logic [DW-1:0] ic_resp_data, dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [MW-1:0] mem_req_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_wait_cycles;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_rw(ic_req_rw),
        .ic_req_addr(ic_req_addr), .ic_req_data(ic_req_data), .ic_req_mask(ic_req_mask),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef MEM_ARB_PERF_EN
        , .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          is_dc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    bit   grant_log[$];
    int   ic_pulses = 0;
    int   dc_pulses = 0;
    int   mem_lat   = 1;
    int   mem_stall = 0;

    function automatic logic [DW-1:0] wdata(input logic [AW-1:0] a);
        return {a, 4'h5, ~a, 4'hA, 32'h1234_5678, a, 4'h0};
    endfunction

    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return {32'hDEADBEEF, 32'hCAFEF00D, 36'h0, a};
    endfunction

    task automatic chkw(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", n, act, exp);
        end
    endtask

    task automatic chki(input string n, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ic(input logic v, input logic rw, input logic [AW-1:0] a);
        ic_req_valid = v; ic_req_rw = rw; ic_req_addr = a;
        ic_req_data = wdata(a); ic_req_mask = a[MW-1:0];
    endtask

    task automatic drive_dc(input logic v, input logic rw, input logic [AW-1:0] a);
        dc_req_valid = v; dc_req_rw = rw; dc_req_addr = a;
        dc_req_data = wdata(a); dc_req_mask = a[MW-1:0];
    endtask

    task automatic chk_zero();
        chk1("z_ic_rdy", ic_req_ready, 1'b0);
        chk1("z_dc_rdy", dc_req_ready, 1'b0);
        chk1("z_mem_vld", mem_req_valid, 1'b0);
        chk1("z_mem_rw", mem_req_rw, 1'b0);
        chkw("z_mem_addr", DW'(mem_req_addr), '0);
        chkw("z_mem_data", mem_req_data, '0);
        chkw("z_mem_mask", DW'(mem_req_mask), '0);
        chk1("z_ic_resp", ic_resp_valid, 1'b0);
        chk1("z_dc_resp", dc_resp_valid, 1'b0);
        chkw("z_ic_rdata", ic_resp_data, '0);
        chkw("z_dc_rdata", dc_resp_data, '0);
`ifdef MEM_ARB_PERF_EN
        chkw("z_perf", DW'(perf_wait_cycles), '0);
`endif
    endtask

    task automatic wait_done(input bit is_read);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (is_read ? (ic_resp_valid || dc_resp_valid) : !mem_req_valid) done = 1'b1;
        end
        chk1("txn_timeout", done, 1'b1);
    endtask

    // Both caches request reads at once; each drops valid once its grant is logged.
    task automatic run_pair(input logic [AW-1:0] ia, input logic [AW-1:0] da);
        bit finished = 1'b0;
        grant_log.delete();
        drive_ic(1'b1, 1'b0, ia);
        drive_dc(1'b1, 1'b0, da);
        for (int i = 0; i < 60 && !finished; i++) begin
            tick();
            foreach (grant_log[k]) begin
                if (grant_log[k]) dc_req_valid = 1'b0;
                else              ic_req_valid = 1'b0;
            end
            if (!ic_req_valid && !dc_req_valid && exp_q.size() == 0 && !mem_req_valid)
                finished = 1'b1;
        end
        chk1("pair_timeout", finished, 1'b1);
        chki("pair_grants", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            chk1("pair_first_dc", grant_log[0], 1'b1);
            chk1("pair_second_ic", grant_log[1], 1'b0);
        end
    endtask

    // Memory model: programmable ready stall and read latency.
    logic          hs, hs_rw, pv, pr, pend;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] pdata;
    int            wcnt, lcnt;

    initial begin
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        pend = 1'b0; wcnt = 0; lcnt = 0; pdata = '0;
        forever begin
            @(posedge clk);
            hs      = mem_req_valid && mem_req_ready && !reset;
            hs_rw   = mem_req_rw;
            hs_addr = mem_req_addr;
            pv      = mem_req_valid;
            pr      = mem_req_ready;
            #1;
            mem_resp_valid = 1'b0;
            if (hs) wcnt = 0;
            else if (pv && !pr) wcnt++;
            mem_req_ready = (wcnt >= mem_stall);
            if (hs && !hs_rw) begin
                pend = 1'b1; lcnt = mem_lat; pdata = rdata(hs_addr);
            end
            if (pend) begin
                if (lcnt <= 1) begin
                    mem_resp_valid = 1'b1; mem_resp_data = pdata; pend = 1'b0;
                end else begin
                    lcnt--;
                end
            end
        end
    end

    // Grant logger and response scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (ic_req_ready || dc_req_ready)
                chk1("rdy_exclusive", ic_req_ready & dc_req_ready, 1'b0);
            if (dc_req_valid && dc_req_ready) begin
                grant_log.push_back(1'b1);
                if (!dc_req_rw) exp_q.push_back({1'b1, rdata(dc_req_addr)});
            end else if (ic_req_valid && ic_req_ready) begin
                grant_log.push_back(1'b0);
                if (!ic_req_rw) exp_q.push_back({1'b0, rdata(ic_req_addr)});
            end
            if (ic_resp_valid) ic_pulses++;
            if (dc_resp_valid) dc_pulses++;
            if (ic_resp_valid || dc_resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk1("resp_unexpected", ic_resp_valid | dc_resp_valid, 1'b0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk1("resp_owner_dc", dc_resp_valid, exp_e.is_dc);
                    chk1("resp_owner_ic", ic_resp_valid, !exp_e.is_dc);
                    chkw("resp_data", exp_e.is_dc ? dc_resp_data : ic_resp_data, exp_e.data);
                end
            end
        end
    end

    typedef struct {
        logic          ic_v, dc_v, ic_rw, dc_rw;
        logic [AW-1:0] ic_a, dc_a;
        logic          exp_ic_rdy, exp_dc_rdy, exp_rw;
        logic [AW-1:0] exp_a;
    } vec_t;

    vec_t vt[8];
    bit   exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int mr, rr, stall_cnt, cyc;
        bit got;
`ifdef MEM_ARB_PERF_EN
        logic [31:0] perf_base;
`endif
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 28'h100, 28'h200, 1'b1, 1'b0, 1'b0, 28'h100};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 28'h101, 28'h201, 1'b0, 1'b1, 1'b0, 28'h201};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 28'h102, 28'h202, 1'b0, 1'b1, 1'b0, 28'h202};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 28'h103, 28'h203, 1'b1, 1'b0, 1'b1, 28'h103};
        vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 28'h104, 28'h204, 1'b0, 1'b1, 1'b1, 28'h204};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 28'h105, 28'h205, 1'b0, 1'b0, 1'b0, 28'h000};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 28'h106, 28'h206, 1'b0, 1'b1, 1'b1, 28'h206};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 28'h107, 28'h207, 1'b0, 1'b1, 1'b0, 28'h207};

        // Reset with both requesters asserting: every output must stay 0.
        reset = 1'b1;
        drive_ic(1'b1, 1'b0, 28'h10);
        drive_dc(1'b1, 1'b0, 28'h20);
        repeat (3) tick();
        chk_zero();
        drive_ic(1'b0, 1'b0, '0);
        drive_dc(1'b0, 1'b0, '0);
        reset = 1'b0;
        tick();

        foreach (vt[i]) begin
            tick();
            drive_ic(vt[i].ic_v, vt[i].ic_rw, vt[i].ic_a);
            drive_dc(vt[i].dc_v, vt[i].dc_rw, vt[i].dc_a);
            #1;
            chk1("vec_ic_rdy", ic_req_ready, vt[i].exp_ic_rdy);
            chk1("vec_dc_rdy", dc_req_ready, vt[i].exp_dc_rdy);
            tick();
            ic_req_valid = 1'b0;
            dc_req_valid = 1'b0;
            chk1("vec_mem_vld", mem_req_valid, vt[i].ic_v | vt[i].dc_v);
            if (vt[i].ic_v || vt[i].dc_v) begin
                chk1("vec_mem_rw", mem_req_rw, vt[i].exp_rw);
                chkw("vec_mem_addr", DW'(mem_req_addr), DW'(vt[i].exp_a));
                chkw("vec_mem_data", mem_req_data, wdata(vt[i].exp_a));
                chkw("vec_mem_mask", DW'(mem_req_mask), DW'(vt[i].exp_a[MW-1:0]));
                wait_done(!vt[i].exp_rw);
            end
        end

        // Single icache read, memory answers 3 cycles after the handshake.
        mem_lat = 3;
        tick();
        ic_pulses = 0; dc_pulses = 0;
        drive_ic(1'b1, 1'b0, 28'h0000010);
        #1;
        chk1("a_ic_rdy", ic_req_ready, 1'b1);
        chk1("a_dc_rdy", dc_req_ready, 1'b0);
        tick();
        ic_req_valid = 1'b0;
        chk1("a_mem_vld", mem_req_valid, 1'b1);
        chkw("a_mem_addr", DW'(mem_req_addr), DW'(28'h10));
        chk1("a_mem_rw", mem_req_rw, 1'b0);
        mr = -1; rr = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_resp_valid && mr < 0) mr = c;
            if (ic_resp_valid && rr < 0) rr = c;
        end
        chki("a_resp_lat", rr - mr, 1);
        chki("a_ic_pulses", ic_pulses, 1);
        chki("a_dc_pulses", dc_pulses, 0);
        chkw("a_ic_rdata", ic_resp_data, rdata(28'h10));
        mem_lat = 1;
        tick();

        // Simultaneous reads: dcache first, icache in the following IDLE.
        run_pair(28'h300, 28'h400);

        // Both requesters held: starvation override every fifth grant.
        grant_log.delete();
        tick();
        drive_ic(1'b1, 1'b1, 28'h500);
        drive_dc(1'b1, 1'b1, 28'h600);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (grant_log.size() >= 10) got = 1'b1;
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        chk1("b_timeout", got, 1'b1);
        for (int i = 0; i < 10; i++)
            if (i < grant_log.size()) chk1("b_grant_order", grant_log[i], exp_order[i]);
        repeat (3) tick();

        // dcache write held off by 5 cycles of mem_req_ready low.
        mem_stall = 5;
        tick();
        tick();
        ic_pulses = 0; dc_pulses = 0;
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h777;
        dc_req_data = wdata(28'h777); dc_req_mask = 16'h000F;
        #1;
        chk1("d_dc_rdy", dc_req_ready, 1'b1);
        tick();
        dc_req_valid = 1'b0;
        stall_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_req_valid && !mem_req_ready) begin
                stall_cnt++;
                chk1("d_rw_stable", mem_req_rw, 1'b1);
                chkw("d_addr_stable", DW'(mem_req_addr), DW'(28'h777));
                chkw("d_data_stable", mem_req_data, wdata(28'h777));
                chkw("d_mask_stable", DW'(mem_req_mask), DW'(16'h000F));
            end else if (mem_req_valid && mem_req_ready) begin
                got = 1'b1;
            end
        end
        chki("d_stall_cycles", stall_cnt, 5);
        mem_stall = 0;
        repeat (6) tick();
        chk1("d_mem_idle", mem_req_valid, 1'b0);
        chki("d_no_pulse", ic_pulses + dc_pulses, 0);

        // Reset while waiting in RESP; the late memory response must be ignored.
        mem_lat = 8;
        tick();
        drive_dc(1'b1, 1'b0, 28'h888);
        #1;
        chk1("e_dc_rdy", dc_req_ready, 1'b1);
        tick();
        dc_req_valid = 1'b0;
        tick();
        chk1("e_in_resp", mem_req_valid, 1'b0);
        reset = 1'b1;
        drive_ic(1'b1, 1'b0, 28'h889);
        drive_dc(1'b1, 1'b0, 28'h88A);
        #1;
        chk_zero();
        repeat (2) tick();
        chk_zero();
        drive_ic(1'b0, 1'b0, '0);
        drive_dc(1'b0, 1'b0, '0);
        reset = 1'b0;
        exp_q.delete();
        ic_pulses = 0; dc_pulses = 0;
        cyc = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mem_req_valid) cyc++;
        end
        chki("e_no_pulse", ic_pulses + dc_pulses, 0);
        chki("e_no_mem_req", cyc, 0);
        mem_lat = 1;
        tick();
        drive_ic(1'b1, 1'b0, 28'h999);
        #1;
        chk1("e_idle_rdy", ic_req_ready, 1'b1);
        tick();
        ic_req_valid = 1'b0;
        wait_done(1'b1);
        tick();

`ifdef MEM_ARB_PERF_EN
        // icache waits 7 cycles behind a dcache read with 5-cycle memory latency.
        mem_lat = 5;
        tick();
        perf_base = perf_wait_cycles;
        run_pair(28'hA00, 28'hB00);
        chkw("f_perf_wait", DW'(perf_wait_cycles - perf_base), DW'(32'd7));
        mem_lat = 1;
        tick();
`endif

        chki("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 300000");
        $fatal(1);
    end

endmodule
